calc_cmd_driver: RTL and testbench
==================================

Name: calc_cmd_driver

Overview:
- Transmit-side companion to the RPN calculator. Accepts a token stream (operands, operators, end-of-expression) over a valid/ready handshake and buffers it.
- Serialises each complete expression onto the calculator's 20-bit command bus as start, enter/arithOp words, then done.
- Captures result and error flags on the done cycle and presents them to the host until acknowledged.
- Sits between the host/testbench and the calculator; drives its data input and observes its outputs.

Parameters:
- FIFO_DEPTH, 16: token buffer entries; must be a power of 2 and at least 2.
- MAX_STACK, 8: calculator stack capacity, used only by the optional depth check.

Ports:
- ck  in  1  clock, rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- tok_valid  in  1  host token valid.
- tok_ready  out  1  driver can accept a token.
- tok_kind  in  2  token kind: 00 NUM, 01 OP, 10 END, 11 reserved (treated as END).
- tok_value  in  16  NUM: operand; OP: one-hot opcode (add 0x1, sub 0x2, and 0x4, swap 0x8, neg 0x10, pop 0x20).
- calc_data  out  20  to calculator: [19:16] one-hot command (start 1, enter 2, arithOp 4, done 8); [15:0] payload.
- calc_result  in  16  calculator result.
- calc_correct, calc_protocolError, calc_stackOverflow, calc_dataOverflow, calc_unexpectedDone  in  1 each  calculator flags.
- res_valid  out  1  capture available.
- res_ack  in  1  host consumes capture.
- res_value  out  16  captured result.
- res_correct  out  1  captured correct flag; 0 if local_err is set.
- res_status  out  5  {local_err, unexpectedDone, dataOverflow, stackOverflow, protocolError}.
- fifo_overflow  out  1  sticky: buffer filled with no END token; cleared only by reset.

Behaviour:
- Reset (asynchronous):
  - FIFO empty; end_cnt = 0; FSM in IDLE.
  - calc_data = 0x8_0000 (idle-done).
  - res_valid = 0; res_value, res_correct and res_status = 0.
  - fifo_overflow = 0; tok_ready = 1.
- Handshake: a token is accepted on a rising edge with tok_valid & tok_ready.
- tok_ready = !full & !flushing & !res_valid_pending_block. It stays 1 in REPORT as long as the FIFO is not full.
- end_cnt counts END tokens currently buffered. It increments on an END push and decrements on an END pop; both in the same cycle means no change.
- Idle bus value is always the done command with payload 0. Command 0 is never driven.
- FSM:
  - IDLE: drive idle-done. If end_cnt > 0, pop the head token.
    - Head is NUM: drive start+value, go to STREAM.
    - Head is not NUM: set local_err and go to FLUSH.
  - STREAM: pop one token per cycle, no bubbles.
    - NUM: drive enter (0x2) + value.
    - OP: drive arithOp (0x4) + opcode.
    - END: drive done, latch calc_result, calc_correct and calc flags on this edge, go to REPORT.
  - FLUSH: pop and discard tokens through END with no bus traffic, then go to REPORT.
  - REPORT: res_valid = 1; hold the idle-done bus. On res_ack, res_valid falls next cycle and the FSM goes to IDLE. The next expression can start the cycle after that.
- Latency: an expression of N tokens, the last being END, occupies exactly N bus cycles (start, N-2 middle words, done). res_valid rises the cycle after the done word.
- FIFO full with end_cnt == 0: set fifo_overflow, flush the entire FIFO, return to IDLE. No report is produced.
- Simultaneous push and pop on a full FIFO: allowed.
- Reset mid-expression: the bus returns immediately to idle-done. This clears the calculator's latched errors on its next edge.

Optional Feature:
- CALC_CMD_DRIVER_DEPTH_CHECK_EN defined: the driver tracks local depth.
  - Depth is 1 after start, +1 on NUM, -1 on add/sub/and/pop, unchanged on neg/swap.
  - A binary op, swap or pop at depth < 2, or a NUM at depth = MAX_STACK, is not sent. Instead the driver drives done that cycle, sets local_err, and flushes the remaining tokens through END.
- Undefined: tokens are streamed verbatim; only the calculator flags are reported and local_err is set only by a bad first token.

Decomposition:
- Package calc_pkg holds:
  - the command codes;
  - the opcode codes;
  - the tok_kind_t enum;
  - the status bit indices;
  - the IDLE_WORD constant.
- One sub-module, calc_tok_fifo: parameterised synchronous FIFO with async reset, full/empty flags and an end_cnt side counter.

Test Plan:
- Tokens NUM 3, NUM 4, OP add, END -> bus 0x1_0003, 0x2_0004, 0x4_0001, 0x8_0000 on consecutive cycles. Report value 7, correct 1, status 0.
- NUM 0x7FFF, NUM 1, OP add, END -> calc_dataOverflow seen on the done cycle. res_status = 0b00100, res_correct 0.
- First token OP neg, then END -> no start driven; bus stays 0x8_0000. res_status = 0b10000.
- FIFO_DEPTH+ tokens, all NUM with no END -> fifo_overflow = 1, FIFO drained, no res_valid.
- With the macro defined, NUM 5, OP sub, END -> bus carries start then done only. local_err set, calculator flags clear.
- Assert rst_l low during STREAM -> calc_data = 0x8_0000 immediately, tok_ready 1, res_valid 0. The next expression runs cleanly.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator command driver: bus command
// codes, one-hot opcodes, token kinds, status bit positions and the idle
// bus word.
package calc_pkg;

   localparam logic [3:0] CMD_START = 4'h1;
   localparam logic [3:0] CMD_ENTER = 4'h2;
   localparam logic [3:0] CMD_ARITH = 4'h4;
   localparam logic [3:0] CMD_DONE  = 4'h8;

   localparam logic [15:0] OP_ADD  = 16'h0001;
   localparam logic [15:0] OP_SUB  = 16'h0002;
   localparam logic [15:0] OP_AND  = 16'h0004;
   localparam logic [15:0] OP_SWAP = 16'h0008;
   localparam logic [15:0] OP_NEG  = 16'h0010;
   localparam logic [15:0] OP_POP  = 16'h0020;

   typedef enum logic [1:0] {
      TOK_NUM = 2'b00,
      TOK_OP  = 2'b01,
      TOK_END = 2'b10,
      TOK_RSV = 2'b11
   } tok_kind_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STREAM = 3'd1,
      S_DONE   = 3'd2,
      S_FLUSH  = 3'd3,
      S_REPORT = 3'd4,
      S_DRAIN  = 3'd5
   } drv_state_t;

   localparam int ST_PROTO   = 0;
   localparam int ST_STKOVF  = 1;
   localparam int ST_DATAOVF = 2;
   localparam int ST_UNEXP   = 3;
   localparam int ST_LOCAL   = 4;

   // The calculator treats a lone done word as "nothing in progress".
   localparam logic [19:0] IDLE_WORD = {CMD_DONE, 16'h0000};

   // Reserved kind 11 behaves as END, so END is simply "upper kind bit set".
   function automatic logic tok_is_end(input logic [1:0] kind);
      return kind[1];
   endfunction

   // Operators that consume two stack entries (swap only reorders them).
   function automatic logic op_needs_two(input logic [15:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_SWAP) || (op == OP_POP);
   endfunction

   // Operators that leave the stack one entry shorter.
   function automatic logic op_pops_one(input logic [15:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_POP);
   endfunction

endpackage

// File: rtl/calc_tok_fifo.sv
// Token buffer for calc_cmd_driver: synchronous FIFO with asynchronous
// reset, full/empty flags and a side counter of buffered END tokens.
module calc_tok_fifo #(
   parameter int DEPTH   = 16,
   parameter int WIDTH   = 18,
   parameter int END_BIT = 17
) (
   input  logic                       ck,
   input  logic                       rst_l,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     end_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic [AW:0]      end_cnt_r;
   logic             push_ok_s;
   logic             pop_ok_s;
   logic             push_end_s;
   logic             pop_end_s;

   assign full    = (count_r == CNT_FULL);
   assign empty   = (count_r == (AW+1)'(0));
   assign rd_data = mem_r[rd_ptr_r];
   assign end_cnt = end_cnt_r;

   // A push into a full buffer is legal only when a pop frees the slot.
   assign push_ok_s  = push & (~full | pop);
   assign pop_ok_s   = pop & ~empty;
   assign push_end_s = push_ok_s & wr_data[END_BIT];
   assign pop_end_s  = pop_ok_s & rd_data[END_BIT];

   // Storage array write port.
   always_ff @(posedge ck) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, occupancy and END-token counter.
   always_ff @(posedge ck or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {(AW+1){1'b0}};
         end_cnt_r <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
         case ({push_end_s, pop_end_s})
            2'b10:   end_cnt_r <= end_cnt_r + CNT_ONE;
            2'b01:   end_cnt_r <= end_cnt_r - CNT_ONE;
            default: end_cnt_r <= end_cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/calc_cmd_driver.sv
// Transmit-side driver for the RPN calculator. Buffers host tokens and
// serialises each complete expression onto the 20-bit command bus, then
// captures the calculator's result and flags for the host.
// Optional build macro: CALC_CMD_DRIVER_DEPTH_CHECK_EN enables local stack
// depth tracking; offending tokens are replaced by a done word and the rest
// of the expression is discarded.
module calc_cmd_driver
   import calc_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_STACK  = 8
) (
   input  logic        ck,
   input  logic        rst_l,
   input  logic        tok_valid,
   output logic        tok_ready,
   input  logic [1:0]  tok_kind,
   input  logic [15:0] tok_value,
   output logic [19:0] calc_data,
   input  logic [15:0] calc_result,
   input  logic        calc_correct,
   input  logic        calc_protocolError,
   input  logic        calc_stackOverflow,
   input  logic        calc_dataOverflow,
   input  logic        calc_unexpectedDone,
   output logic        res_valid,
   input  logic        res_ack,
   output logic [15:0] res_value,
   output logic        res_correct,
   output logic [4:0]  res_status,
   output logic        fifo_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   drv_state_t  state_r, state_n;
   logic [19:0] calc_data_r, calc_data_n;
   logic        res_valid_r;
   logic [15:0] res_value_r;
   logic        res_correct_r;
   logic [4:0]  res_status_r;
   logic        fifo_overflow_r;
   logic        err_r;

   logic        push_s;
   logic        pop_s;
   logic [17:0] head_s;
   logic        full_s;
   logic        empty_s;
   logic [AW:0] end_cnt_s;
   tok_kind_t   head_kind_s;
   logic [15:0] head_val_s;
   logic        head_is_end_s;

   logic        set_ovf_s;
   logic        set_err_s;
   logic        cap_calc_s;
   logic        cap_err_s;
   logic        ack_s;
   logic [4:0]  calc_status_s;
   logic [4:0]  err_status_s;

`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
   localparam int DEPTH_W = $clog2(MAX_STACK + 1) + 1;
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_STACK);
   logic [DEPTH_W-1:0] depth_r, depth_n;
`endif

   assign tok_ready     = ~full_s & (state_r != S_DRAIN);
   assign push_s        = tok_valid & tok_ready;
   assign head_kind_s   = tok_kind_t'(head_s[17:16]);
   assign head_val_s    = head_s[15:0];
   assign head_is_end_s = tok_is_end(head_s[17:16]);

   assign calc_data     = calc_data_r;
   assign res_valid     = res_valid_r;
   assign res_value     = res_value_r;
   assign res_correct   = res_correct_r;
   assign res_status    = res_status_r;
   assign fifo_overflow = fifo_overflow_r;

   calc_tok_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .WIDTH   (18),
      .END_BIT (17)
   ) u_fifo (
      .ck      (ck),
      .rst_l   (rst_l),
      .push    (push_s),
      .wr_data ({tok_kind, tok_value}),
      .pop     (pop_s),
      .rd_data (head_s),
      .full    (full_s),
      .empty   (empty_s),
      .end_cnt (end_cnt_s)
   );

   // Assemble the status words for a calculator-completed and a locally rejected expression.
   always_comb begin
      calc_status_s             = 5'b00000;
      calc_status_s[ST_PROTO]   = calc_protocolError;
      calc_status_s[ST_STKOVF]  = calc_stackOverflow;
      calc_status_s[ST_DATAOVF] = calc_dataOverflow;
      calc_status_s[ST_UNEXP]   = calc_unexpectedDone;
      calc_status_s[ST_LOCAL]   = err_r;
      err_status_s              = 5'b00000;
      err_status_s[ST_LOCAL]    = 1'b1;
   end

   // Next-state, token pop and next bus word.
   always_comb begin
      state_n     = state_r;
      calc_data_n = IDLE_WORD;
      pop_s       = 1'b0;
      set_ovf_s   = 1'b0;
      set_err_s   = 1'b0;
      cap_calc_s  = 1'b0;
      cap_err_s   = 1'b0;
      ack_s       = 1'b0;
`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
      depth_n     = depth_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (full_s && (end_cnt_s == (AW+1)'(0))) begin
               set_ovf_s = 1'b1;
               state_n   = S_DRAIN;
            end else if (end_cnt_s != (AW+1)'(0)) begin
               pop_s = 1'b1;
               if (head_kind_s == TOK_NUM) begin
                  calc_data_n = {CMD_START, head_val_s};
                  state_n     = S_STREAM;
`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
                  depth_n     = DEPTH_ONE;
`endif
               end else if (head_is_end_s) begin
                  // Empty expression: nothing left to discard.
                  cap_err_s = 1'b1;
                  state_n   = S_REPORT;
               end else begin
                  set_err_s = 1'b1;
                  state_n   = S_FLUSH;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_STREAM: begin
            if (empty_s) begin
               state_n = S_STREAM;
            end else begin
               pop_s = 1'b1;
               if (head_is_end_s) begin
                  calc_data_n = IDLE_WORD;
                  state_n     = S_DONE;
               end else if (head_kind_s == TOK_NUM) begin
`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
                  if (depth_r == DEPTH_MAX) begin
                     set_err_s = 1'b1;
                     state_n   = S_FLUSH;
                  end else begin
                     calc_data_n = {CMD_ENTER, head_val_s};
                     depth_n     = depth_r + DEPTH_ONE;
                  end
`else
                  calc_data_n = {CMD_ENTER, head_val_s};
`endif
               end else begin
`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
                  if (op_needs_two(head_val_s) && (depth_r < DEPTH_TWO)) begin
                     set_err_s = 1'b1;
                     state_n   = S_FLUSH;
                  end else if (op_pops_one(head_val_s)) begin
                     calc_data_n = {CMD_ARITH, head_val_s};
                     depth_n     = depth_r - DEPTH_ONE;
                  end else begin
                     calc_data_n = {CMD_ARITH, head_val_s};
                  end
`else
                  calc_data_n = {CMD_ARITH, head_val_s};
`endif
               end
            end
         end
         S_DONE: begin
            // The done word is on the bus this cycle; the calculator's verdict is valid now.
            cap_calc_s = 1'b1;
            state_n    = S_REPORT;
         end
         S_FLUSH: begin
            if (empty_s) begin
               state_n = S_FLUSH;
            end else begin
               pop_s = 1'b1;
               if (head_is_end_s) begin
                  cap_err_s = 1'b1;
                  state_n   = S_REPORT;
               end else begin
                  state_n = S_FLUSH;
               end
            end
         end
         S_REPORT: begin
            if (res_ack) begin
               ack_s   = 1'b1;
               state_n = S_IDLE;
            end else begin
               state_n = S_REPORT;
            end
         end
         S_DRAIN: begin
            if (empty_s) begin
               state_n = S_IDLE;
            end else begin
               pop_s = 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // FSM state and registered command bus.
   always_ff @(posedge ck or negedge rst_l) begin
      if (!rst_l) begin
         state_r     <= S_IDLE;
         calc_data_r <= IDLE_WORD;
      end else begin
         state_r     <= state_n;
         calc_data_r <= calc_data_n;
      end
   end

   // Result capture, host handshake and sticky/local error flags.
   always_ff @(posedge ck or negedge rst_l) begin
      if (!rst_l) begin
         res_valid_r     <= 1'b0;
         res_value_r     <= 16'h0000;
         res_correct_r   <= 1'b0;
         res_status_r    <= 5'b00000;
         fifo_overflow_r <= 1'b0;
         err_r           <= 1'b0;
      end else begin
         if (cap_calc_s) begin
            res_valid_r   <= 1'b1;
            res_value_r   <= calc_result;
            res_correct_r <= calc_correct & ~err_r;
            res_status_r  <= calc_status_s;
         end else if (cap_err_s) begin
            res_valid_r   <= 1'b1;
            res_value_r   <= 16'h0000;
            res_correct_r <= 1'b0;
            res_status_r  <= err_status_s;
         end else if (ack_s) begin
            res_valid_r   <= 1'b0;
         end
         if (set_ovf_s) begin
            fifo_overflow_r <= 1'b1;
         end
         if (set_err_s) begin
            err_r <= 1'b1;
         end else if (ack_s) begin
            err_r <= 1'b0;
         end
      end
   end

`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
   // Locally tracked calculator stack depth.
   always_ff @(posedge ck or negedge rst_l) begin
      if (!rst_l) begin
         depth_r <= {DEPTH_W{1'b0}};
      end else begin
         depth_r <= depth_n;
      end
   end
`endif

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Self-checking bench for calc_cmd_driver with a tiny RPN calculator model
// and scoreboards for bus words and host reports.
module tb_calc_cmd_driver;
   import calc_pkg::*;

   localparam int FIFO_DEPTH = 16;
   localparam int MAX_STACK  = 8;

   logic        ck = 1'b0;
   logic        rst_l;
   logic        tok_valid;
   logic        tok_ready;
   logic [1:0]  tok_kind;
   logic [15:0] tok_value;
   logic [19:0] calc_data;
   logic [15:0] calc_result;
   logic        calc_correct;
   logic        calc_protocolError;
   logic        calc_stackOverflow;
   logic        calc_dataOverflow;
   logic        calc_unexpectedDone;
   logic        res_valid;
   logic        res_ack;
   logic [15:0] res_value;
   logic        res_correct;
   logic [4:0]  res_status;
   logic        fifo_overflow;

   always #5 ck = ~ck;

   calc_cmd_driver #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_STACK(MAX_STACK)) dut (
      .ck(ck), .rst_l(rst_l),
      .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_kind(tok_kind), .tok_value(tok_value),
      .calc_data(calc_data), .calc_result(calc_result),
      .calc_correct(calc_correct), .calc_protocolError(calc_protocolError),
      .calc_stackOverflow(calc_stackOverflow), .calc_dataOverflow(calc_dataOverflow),
      .calc_unexpectedDone(calc_unexpectedDone),
      .res_valid(res_valid), .res_ack(res_ack), .res_value(res_value),
      .res_correct(res_correct), .res_status(res_status),
      .fifo_overflow(fifo_overflow)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cyc = 0;
   logic in_frame;

   typedef struct packed {
      logic [15:0] value;
      logic        correct;
      logic [4:0]  status;
      logic        chk_lat;
   } exp_res_t;

   logic [19:0] exp_bus_q [$];
   exp_res_t    exp_res_q [$];

   // Cycle counter used for the report-latency check.
   always @(posedge ck) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- calculator model ----------------
   logic [15:0] stk [0:15];
   int          sp;
   logic        m_in_expr;
   logic        m_ovf;
   logic [15:0] m_a, m_b, m_top, m_sum, m_diff;
   logic        add_ovf, sub_ovf, m_done;

   // Operand views and overflow detection for the model.
   always_comb begin
      m_a     = (sp >= 2) ? stk[sp-2] : 16'h0000;
      m_b     = (sp >= 2) ? stk[sp-1] : 16'h0000;
      m_top   = (sp >= 1) ? stk[sp-1] : 16'h0000;
      m_sum   = m_a + m_b;
      m_diff  = m_a - m_b;
      add_ovf = (m_a[15] == m_b[15]) && (m_sum[15] != m_a[15]);
      sub_ovf = (m_a[15] != m_b[15]) && (m_diff[15] != m_a[15]);
      m_done  = m_in_expr && (calc_data[19:16] == CMD_DONE);
   end

   assign calc_result         = m_top;
   assign calc_correct        = m_done && !m_ovf && (sp == 1);
   assign calc_dataOverflow   = m_done && m_ovf;
   assign calc_protocolError  = 1'b0;
   assign calc_stackOverflow  = 1'b0;
   assign calc_unexpectedDone = 1'b0;

   // Model stack updated from the command bus.
   always @(posedge ck or negedge rst_l) begin
      if (!rst_l) begin
         sp <= 0; m_in_expr <= 1'b0; m_ovf <= 1'b0;
      end else begin
         case (calc_data[19:16])
            CMD_START: begin stk[0] <= calc_data[15:0]; sp <= 1; m_in_expr <= 1'b1; m_ovf <= 1'b0; end
            CMD_ENTER: if (m_in_expr && sp < 16) begin stk[sp] <= calc_data[15:0]; sp <= sp + 1; end
            CMD_ARITH: begin
               if (m_in_expr && calc_data[15:0] == OP_ADD && sp >= 2) begin
                  stk[sp-2] <= m_sum; sp <= sp - 1; m_ovf <= m_ovf | add_ovf;
               end else if (m_in_expr && calc_data[15:0] == OP_SUB && sp >= 2) begin
                  stk[sp-2] <= m_diff; sp <= sp - 1; m_ovf <= m_ovf | sub_ovf;
               end else if (m_in_expr && calc_data[15:0] == OP_NEG && sp >= 1) begin
                  stk[sp-1] <= 16'h0000 - m_top;
               end
            end
            CMD_DONE: m_in_expr <= 1'b0;
            default: ;
         endcase
      end
   end

   // ---------------- monitors ----------------
   initial begin : bus_mon
      logic [19:0] e;
      forever begin
         @(negedge ck);
         if (rst_l && (in_frame || calc_data[19:16] == CMD_START)) begin
            if (exp_bus_q.size() == 0) begin
               check_val("bus_extra", 32'(calc_data), 32'(IDLE_WORD));
               in_frame = 1'b0;
            end else begin
               e = exp_bus_q.pop_front();
               check_val("bus_word", 32'(calc_data), 32'(e));
               if (e[19:16] == CMD_DONE) begin
                  in_frame = 1'b0;
                  done_cyc = cyc;
               end else begin
                  in_frame = 1'b1;
               end
            end
         end
      end
   end

   initial begin : res_mon
      exp_res_t r;
      forever begin
         @(negedge ck);
         if (res_ack) begin
            res_ack = 1'b0;
         end else if (res_valid) begin
            if (exp_res_q.size() == 0) begin
               check_val("res_extra", 32'(res_valid), 32'(0));
            end else begin
               r = exp_res_q.pop_front();
               check_val("res_value", 32'(res_value), 32'(r.value));
               check_val("res_correct", 32'(res_correct), 32'(r.correct));
               check_val("res_status", 32'(res_status), 32'(r.status));
               if (r.chk_lat) check_val("res_latency", 32'(cyc), 32'(done_cyc + 1));
            end
            res_ack = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_tok(input logic [1:0] k, input logic [15:0] v);
      int waited = 0;
      @(negedge ck);
      tok_valid = 1'b1; tok_kind = k; tok_value = v;
      while (!tok_ready && waited < 200) begin
         @(negedge ck);
         waited++;
      end
      if (!tok_ready) begin
         check_val("tok_accept_timeout", 32'(tok_ready), 32'(1));
      end else begin
         @(posedge ck);
         #1;
      end
      tok_valid = 1'b0;
   endtask

   task automatic exp_bus(input logic [3:0] cmd, input logic [15:0] pay);
      exp_bus_q.push_back({cmd, pay});
   endtask

   task automatic exp_rep(input logic [15:0] v, input logic c, input logic [4:0] s, input logic lat);
      exp_res_t r;
      r.value = v; r.correct = c; r.status = s; r.chk_lat = lat;
      exp_res_q.push_back(r);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_res_q.size() != 0 || exp_bus_q.size() != 0 || res_valid) && n < 400) begin
         @(negedge ck);
         n++;
      end
      if (n >= 400) check_val("idle_timeout", 32'(exp_res_q.size() + exp_bus_q.size()), 32'(0));
      repeat (2) @(negedge ck);
   endtask

   task automatic run_add_3_4();
      exp_bus(CMD_START, 16'h0003); exp_bus(CMD_ENTER, 16'h0004);
      exp_bus(CMD_ARITH, OP_ADD);   exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'h0007, 1'b1, 5'b00000, 1'b1);
      send_tok(TOK_NUM, 16'h0003); send_tok(TOK_NUM, 16'h0004);
      send_tok(TOK_OP, OP_ADD);    send_tok(TOK_END, 16'h0000);
      wait_idle();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_l = 1'b0; tok_valid = 1'b0; tok_kind = 2'b00; tok_value = 16'h0000;
      res_ack = 1'b0; in_frame = 1'b0;
      repeat (3) @(negedge ck);
      check_val("rst_calc_data", 32'(calc_data), 32'h0008_0000);
      check_val("rst_tok_ready", 32'(tok_ready), 32'(1));
      check_val("rst_res_valid", 32'(res_valid), 32'(0));
      check_val("rst_res_value", 32'(res_value), 32'(0));
      check_val("rst_res_correct", 32'(res_correct), 32'(0));
      check_val("rst_res_status", 32'(res_status), 32'(0));
      check_val("rst_fifo_overflow", 32'(fifo_overflow), 32'(0));
      rst_l = 1'b1;
      repeat (2) @(negedge ck);

      // 3 + 4
      run_add_3_4();

      // 0x7FFF + 1 overflows
      exp_bus(CMD_START, 16'h7FFF); exp_bus(CMD_ENTER, 16'h0001);
      exp_bus(CMD_ARITH, OP_ADD);   exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'h8000, 1'b0, 5'b00100, 1'b1);
      send_tok(TOK_NUM, 16'h7FFF); send_tok(TOK_NUM, 16'h0001);
      send_tok(TOK_OP, OP_ADD);    send_tok(TOK_END, 16'h0000);
      wait_idle();

      // Bad first token: nothing on the bus, local error reported
      exp_rep(16'h0000, 1'b0, 5'b10000, 1'b0);
      send_tok(TOK_OP, OP_NEG); send_tok(TOK_END, 16'h0000);
      wait_idle();

      // 10 - 3, negated
      exp_bus(CMD_START, 16'h000A); exp_bus(CMD_ENTER, 16'h0003);
      exp_bus(CMD_ARITH, OP_SUB);   exp_bus(CMD_ARITH, OP_NEG);
      exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'hFFF9, 1'b1, 5'b00000, 1'b1);
      send_tok(TOK_NUM, 16'h000A); send_tok(TOK_NUM, 16'h0003);
      send_tok(TOK_OP, OP_SUB);    send_tok(TOK_OP, OP_NEG);
      send_tok(TOK_END, 16'h0000);
      wait_idle();

      // Two expressions back to back, second one with reserved kind as END
      exp_bus(CMD_START, 16'h0001); exp_bus(CMD_ENTER, 16'h0002);
      exp_bus(CMD_ARITH, OP_ADD);   exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'h0003, 1'b1, 5'b00000, 1'b1);
      exp_bus(CMD_START, 16'h8000); exp_bus(CMD_ENTER, 16'h0001);
      exp_bus(CMD_ARITH, OP_SUB);   exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'h7FFF, 1'b0, 5'b00100, 1'b1);
      send_tok(TOK_NUM, 16'h0001); send_tok(TOK_NUM, 16'h0002);
      send_tok(TOK_OP, OP_ADD);    send_tok(TOK_END, 16'h0000);
      send_tok(TOK_NUM, 16'h8000); send_tok(TOK_NUM, 16'h0001);
      send_tok(TOK_OP, OP_SUB);    send_tok(TOK_RSV, 16'h0000);
      wait_idle();

`ifdef CALC_CMD_DRIVER_DEPTH_CHECK_EN
      // Binary op at depth 1 is refused
      exp_bus(CMD_START, 16'h0005); exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'h0000, 1'b0, 5'b10000, 1'b1);
      send_tok(TOK_NUM, 16'h0005); send_tok(TOK_OP, OP_SUB);
      send_tok(TOK_END, 16'h0000);
      wait_idle();

      // NUM pushed at full local depth is refused
      exp_bus(CMD_START, 16'h0001);
      for (int i = 2; i <= MAX_STACK; i++) exp_bus(CMD_ENTER, 16'(i));
      exp_bus(CMD_DONE, 16'h0000);
      exp_rep(16'h0000, 1'b0, 5'b10000, 1'b1);
      for (int i = 1; i <= MAX_STACK + 1; i++) send_tok(TOK_NUM, 16'(i));
      send_tok(TOK_END, 16'h0000);
      wait_idle();
`endif

      // FIFO fills with no END: sticky overflow, drained, no report
      begin
         int n;
         for (int i = 0; i < FIFO_DEPTH; i++) send_tok(TOK_NUM, 16'(i));
         n = 0;
         while (!fifo_overflow && n < 50) begin @(negedge ck); n++; end
         check_val("ovf_set", 32'(fifo_overflow), 32'(1));
         n = 0;
         while (!tok_ready && n < 60) begin @(negedge ck); n++; end
         check_val("ovf_drained_ready", 32'(tok_ready), 32'(1));
         repeat (5) @(negedge ck);
         check_val("ovf_no_report", 32'(res_valid), 32'(0));
         check_val("ovf_sticky", 32'(fifo_overflow), 32'(1));
      end
      run_add_3_4();

      // Reset in the middle of streaming
      exp_bus(CMD_START, 16'h0001); exp_bus(CMD_ENTER, 16'h0002);
      exp_bus(CMD_ENTER, 16'h0003); exp_bus(CMD_ENTER, 16'h0004);
      exp_bus(CMD_ARITH, OP_ADD);   exp_bus(CMD_ARITH, OP_ADD);
      exp_bus(CMD_ARITH, OP_ADD);   exp_bus(CMD_DONE, 16'h0000);
      for (int i = 1; i <= 4; i++) send_tok(TOK_NUM, 16'(i));
      for (int i = 0; i < 3; i++) send_tok(TOK_OP, OP_ADD);
      send_tok(TOK_END, 16'h0000);
      repeat (3) @(posedge ck);
      #2;
      check_val("midrst_in_stream", 32'(calc_data[19:16] != CMD_DONE), 32'(1));
      rst_l = 1'b0;
      #1;
      check_val("midrst_calc_data", 32'(calc_data), 32'h0008_0000);
      check_val("midrst_tok_ready", 32'(tok_ready), 32'(1));
      check_val("midrst_res_valid", 32'(res_valid), 32'(0));
      check_val("midrst_ovf_clear", 32'(fifo_overflow), 32'(0));
      exp_bus_q.delete();
      exp_res_q.delete();
      in_frame = 1'b0;
      repeat (2) @(negedge ck);
      rst_l = 1'b1;
      repeat (2) @(negedge ck);
      run_add_3_4();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
